// File: rtl/fwft_write_skid_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fwft_write_skid_logic_pkg
// Brief   : Shared FIFO types and constants for the write-side skid pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package fwft_write_skid_logic_pkg;

  // Pipeline occupancy, 0..SKID_DEPTH
  typedef logic [1:0] occ_t;

  localparam int SKID_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/fwft_write_skid_logic.sv
`default_nettype none
// ============================================================================
// Module  : fwft_write_skid_logic
// Brief   : Two-entry write skid pipeline feeding the FIFO RAM, with a
//           registered user full flag isolated from the core full path.
// Revision: 1.0 - initial release
// ============================================================================
module fwft_write_skid_logic
  import fwft_write_skid_logic_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  WR_CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  FIFO_FULL,
  output logic                  RAM_WE,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  output logic                  USER_FULL,
  output logic                  WR_ACK,
  output logic                  OVERFLOW,
  output logic                  PIPE_EMPTY,
  output logic                  STAGE1_VALID,
  output logic                  STAGE2_VALID
);

  logic                  r_stage1_valid;
  logic                  r_stage2_valid;
  logic [DATA_WIDTH-1:0] r_stage1_data;
  logic [DATA_WIDTH-1:0] r_stage2_data;
  logic                  r_user_full;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_pipe_empty;

  logic                  w_accept;
  logic                  w_drain;
  occ_t                  w_occ;
  occ_t                  w_occ_next;

  assign w_accept   = WR_EN & ~r_user_full;
  assign w_drain    = r_stage1_valid & ~FIFO_FULL;
  assign w_occ      = {1'b0, r_stage1_valid} + {1'b0, r_stage2_valid};
  assign w_occ_next = w_occ + {1'b0, w_accept} - {1'b0, w_drain};

  // Stage1 always holds the oldest word; stage2 only fills behind it.
  always_ff @(posedge WR_CLK or posedge RST) begin
    if (RST) begin
      r_stage1_valid <= 1'b0;
      r_stage2_valid <= 1'b0;
      r_stage1_data  <= '0;
      r_stage2_data  <= '0;
    end else if (w_drain) begin
      if (r_stage2_valid) begin
        r_stage1_data <= r_stage2_data;
        if (w_accept) begin
          r_stage2_data <= DIN;
        end else begin
          r_stage2_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_stage1_data <= DIN;
      end else begin
        r_stage1_valid <= 1'b0;
      end
    end else if (!r_stage1_valid) begin
      if (w_accept) begin
        r_stage1_valid <= 1'b1;
        r_stage1_data  <= DIN;
      end
    end else if (!r_stage2_valid && w_accept) begin
      r_stage2_valid <= 1'b1;
      r_stage2_data  <= DIN;
    end
  end

  always_ff @(posedge WR_CLK or posedge RST) begin
    if (RST) begin
      r_user_full  <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_overflow   <= 1'b0;
      r_pipe_empty <= 1'b1;
    end else begin
      r_user_full  <= (w_occ_next == occ_t'(SKID_DEPTH));
      r_wr_ack     <= w_accept;
      r_overflow   <= WR_EN & r_user_full;
      r_pipe_empty <= (w_occ_next == occ_t'(0));
    end
  end

  assign RAM_WE       = w_drain;
  assign RAM_DIN      = r_stage1_data;
  assign USER_FULL    = r_user_full;
  assign WR_ACK       = r_wr_ack;
  assign OVERFLOW     = r_overflow;
  assign PIPE_EMPTY   = r_pipe_empty;
  assign STAGE1_VALID = r_stage1_valid;
  assign STAGE2_VALID = r_stage2_valid;

endmodule
`default_nettype wire
